// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer width and Gray/binary conversion helpers.
// Helpers work on 32-bit zero-extended values so any pointer width up to 32 bits can use them.
package fifo_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int PTR_W         = ADDR_SIZE_DEF + 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_sync_r2w.sv
// Two-flop synchronizer bringing a Gray pointer into the local clock domain.
// Parameterised on width so the read side can mirror it.
module fifo_sync_r2w
  import fifo_pkg::*;
#(
  parameter int WIDTH = PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;

  always_comb begin
    q1_d = d;
    q2_d = q1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= q1_d;
      q2_q <= q2_d;
    end
  end

  assign q = q2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full flags and fill level for the async FIFO.
// Define FIFO_WOVERFLOW_EN to add the sticky woverflow output.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int          ADDR_SIZE    = 4,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   rptr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
`ifdef FIFO_WOVERFLOW_EN
  output logic                 woverflow,
`endif
  output logic [ADDR_SIZE:0]   wlevel
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] wq2_rptr;
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          wen;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_cmp;

  fifo_sync_r2w #(.WIDTH(PW)) u_sync_r2w (
    .clk (wclk),
    .rst (wrst),
    .d   (rptr),
    .q   (wq2_rptr)
  );

  // Full when the next write pointer is a whole lap ahead of the synchronized read pointer.
  always_comb begin
    wen            = winc & ~wfull_q;
    wbin_d         = wbin_q + PW'(wen);
    wptr_d         = PW'(bin2gray(32'(wbin_d)));
    full_cmp       = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    wfull_d        = (wptr_d == full_cmp);
    rbin_sync      = PW'(gray2bin(32'(wq2_rptr)));
    wlevel_d       = wbin_d - rbin_sync;
    walmost_full_d = (32'(wlevel_d) >= AFULL_THRESH);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
    end
  end

`ifdef FIFO_WOVERFLOW_EN
  logic woverflow_q, woverflow_d;

  always_comb begin
    woverflow_d = woverflow_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      woverflow_q <= 1'b0;
    end else begin
      woverflow_q <= woverflow_d;
    end
  end

  assign woverflow = woverflow_q;
`endif

  assign waddr        = wbin_q[ADDR_SIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed scenarios plus random traffic against a count-based model.
module tb_fifo_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst = 1'b1;
  logic       winc = 1'b0;
  logic [4:0] rptr = '0;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
`ifdef FIFO_WOVERFLOW_EN
  logic       woverflow;
`endif

  int checks = 0;
  int errors = 0;

  // Model: total accepted writes, read counts seen through the two-edge lag, derived flags.
  int m_wtot  = 0;
  int m_rs1   = 0;
  int m_rs2   = 0;
  int m_level = 0;
  bit m_full  = 0;
  bit m_af    = 0;
  bit m_ovf   = 0;
  int rcnt    = 0;

  fifo_wptr_full #(.ADDR_SIZE(4), .AFULL_THRESH(12)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .rptr         (rptr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
`ifdef FIFO_WOVERFLOW_EN
    .woverflow    (woverflow),
`endif
    .wlevel       (wlevel)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray5(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  // One clock: drive inputs on the falling edge, advance the model at the rising edge, settle #1.
  task automatic step(input bit rst_i, input bit inc_i, input int rc_i);
    @(negedge wclk);
    wrst = rst_i;
    winc = inc_i;
    rptr = gray5(rc_i);
    @(posedge wclk);
    if (rst_i) begin
      m_wtot = 0; m_rs1 = 0; m_rs2 = 0; m_level = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      if (inc_i && m_full) m_ovf = 1;
      if (inc_i && !m_full) m_wtot++;
      m_level = m_wtot - m_rs2;
      m_rs2   = m_rs1;
      m_rs1   = rc_i;
      m_full  = (m_level == 16);
      m_af    = (m_level >= 12);
    end
    #1;
  endtask

  task automatic do_reset();
    rcnt = 0;
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 0);
  endtask

  task automatic test_reset();
    rcnt = 0;
    step(1, 1, 0);
    step(1, 1, 0);
    checks++;
    if ({waddr, wptr, wfull, walmost_full, wlevel} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: waddr=%0d wptr=%b wfull=%b af=%b wlevel=%0d, required all 0",
               waddr, wptr, wfull, walmost_full, wlevel);
    end
`ifdef FIFO_WOVERFLOW_EN
    checks++;
    if (woverflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_woverflow: got %b, required 0", woverflow);
    end
`endif
    winc = 0;
    step(0, 0, 0);
    checks++;
    if (waddr !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_waddr: got %0d, required 0", waddr);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (waddr !== 4'(i)) begin
        errors++;
        $display("FAIL fill_waddr[%0d]: got %0d, required %0d", i, waddr, i);
      end
      checks++;
      if (wfull !== 1'b0) begin
        errors++;
        $display("FAIL fill_early_full[%0d]: got %b, required 0", i, wfull);
      end
      step(0, 1, 0);
    end
    checks++;
    if (wfull !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11000) begin
      errors++;
      $display("FAIL fill_full: wfull=%b wlevel=%0d wptr=%b, required 1/16/11000",
               wfull, wlevel, wptr);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      checks++;
      if (waddr !== 4'd0 || wptr !== 5'b11000 || wfull !== 1'b1) begin
        errors++;
        $display("FAIL overflow_hold[%0d]: waddr=%0d wptr=%b wfull=%b, required 0/11000/1",
                 i, waddr, wptr, wfull);
      end
    end
`ifdef FIFO_WOVERFLOW_EN
    checks++;
    if (woverflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_flag: got %b, required 1", woverflow);
    end
`endif
  endtask

  task automatic test_release();
    step(0, 0, 1);
    checks++;
    if (wfull !== 1'b1 || wlevel !== 5'd16) begin
      errors++;
      $display("FAIL release_edge1: wfull=%b wlevel=%0d, required 1/16", wfull, wlevel);
    end
    step(0, 0, 1);
    checks++;
    if (wfull !== 1'b1 || wlevel !== 5'd16) begin
      errors++;
      $display("FAIL release_edge2: wfull=%b wlevel=%0d, required 1/16", wfull, wlevel);
    end
    step(0, 0, 1);
    checks++;
    if (wfull !== 1'b0 || wlevel !== 5'd15) begin
      errors++;
      $display("FAIL release_edge3: wfull=%b wlevel=%0d, required 0/15", wfull, wlevel);
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    for (int i = 0; i < 11; i++) step(0, 1, 0);
    checks++;
    if (walmost_full !== 1'b0 || wlevel !== 5'd11) begin
      errors++;
      $display("FAIL afull_11: af=%b wlevel=%0d, required 0/11", walmost_full, wlevel);
    end
    step(0, 1, 0);
    checks++;
    if (walmost_full !== 1'b1 || wlevel !== 5'd12) begin
      errors++;
      $display("FAIL afull_12: af=%b wlevel=%0d, required 1/12", walmost_full, wlevel);
    end
  endtask

  task automatic test_wrap();
    int fulls;
    int maxlvl;
    fulls  = 0;
    maxlvl = 0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      rcnt = (i - 1 > 4) ? i - 1 - 4 : 0;
      step(0, 1, rcnt);
      if (wfull) fulls++;
      if (int'(wlevel) > maxlvl) maxlvl = int'(wlevel);
      if (i == 31) begin
        checks++;
        if (wptr !== 5'b10000) begin
          errors++;
          $display("FAIL wrap_wptr31: got %b, required 10000", wptr);
        end
      end
      if (i == 32) begin
        checks++;
        if (wptr !== 5'b00000 || waddr !== 4'd0) begin
          errors++;
          $display("FAIL wrap_wptr32: wptr=%b waddr=%0d, required 00000/0", wptr, waddr);
        end
      end
    end
    checks++;
    if (fulls != 0 || maxlvl > 7) begin
      errors++;
      $display("FAIL wrap_bounds: full_cycles=%0d max_level=%0d, required 0 and <=7", fulls, maxlvl);
    end
  endtask

  task automatic test_random();
    bit inc;
    bit rst_now;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_now = ($urandom_range(0, 99) == 0);
      inc     = ($urandom_range(0, 99) < 65);
      if (rst_now) rcnt = 0;
      else if (rcnt < m_wtot && $urandom_range(0, 99) < 45) rcnt++;
      step(rst_now, inc, rcnt);
      checks++;
      if (waddr !== 4'(m_wtot % 16) || wptr !== gray5(m_wtot) || wfull !== m_full ||
          walmost_full !== m_af || wlevel !== 5'(m_level)) begin
        errors++;
        $display("FAIL random[%0d]: waddr=%0d wptr=%b wfull=%b af=%b wlevel=%0d, required %0d/%b/%b/%b/%0d",
                 i, waddr, wptr, wfull, walmost_full, wlevel,
                 m_wtot % 16, gray5(m_wtot), m_full, m_af, m_level);
      end
`ifdef FIFO_WOVERFLOW_EN
      checks++;
      if (woverflow !== m_ovf) begin
        errors++;
        $display("FAIL random_ovf[%0d]: got %b, required %b", i, woverflow, m_ovf);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_almost_full();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
